// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer step points, period lengths and mode encoding.
package apu_pkg;

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } frame_mode_e;

    localparam int unsigned STEP_S1 = 7457;
    localparam int unsigned STEP_S2 = 14913;
    localparam int unsigned STEP_S3 = 22371;
    localparam int unsigned STEP_S4 = 29829;
    localparam int unsigned STEP_S5 = 37281;

    localparam int unsigned PERIOD_4STEP = 29830;
    localparam int unsigned PERIOD_5STEP = 37282;

endpackage

// File: rtl/frame_step_decode.sv
// Combinational step decoder: maps a counter value and sequencer mode to the
// quarter/half/IRQ-set strobes and a wrap flag for values at or past the period.
module frame_step_decode
    import apu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  frame_mode_e      mode_i,
    output logic             quarter_o,
    output logic             half_o,
    output logic             irq_set_o,
    output logic             wrap_o
);

    always_comb begin
        quarter_o = 1'b0;
        half_o    = 1'b0;
        irq_set_o = 1'b0;
        wrap_o    = 1'b0;
        if (mode_i == MODE_4STEP) begin
            wrap_o    = (cnt_i >= CNT_W'(PERIOD_4STEP));
            quarter_o = (cnt_i == CNT_W'(STEP_S1)) || (cnt_i == CNT_W'(STEP_S2)) ||
                        (cnt_i == CNT_W'(STEP_S3)) || (cnt_i == CNT_W'(STEP_S4));
            half_o    = (cnt_i == CNT_W'(STEP_S2)) || (cnt_i == CNT_W'(STEP_S4));
            irq_set_o = (cnt_i == CNT_W'(STEP_S4));
        end else begin
            // S4 is deliberately silent in 5-step mode
            wrap_o    = (cnt_i >= CNT_W'(PERIOD_5STEP));
            quarter_o = (cnt_i == CNT_W'(STEP_S1)) || (cnt_i == CNT_W'(STEP_S2)) ||
                        (cnt_i == CNT_W'(STEP_S3)) || (cnt_i == CNT_W'(STEP_S5));
            half_o    = (cnt_i == CNT_W'(STEP_S2)) || (cnt_i == CNT_W'(STEP_S5));
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// APU frame sequencer ($4017): 4/5-step quarter/half-frame pulse generator.
// Optional frame IRQ (inhibit latch, flag, ack) compiled in with FRAME_SEQ_IRQ_EN.
module frame_sequencer
    import apu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iCpuTick,
    input  logic       iWrite,
    input  logic [7:0] iData,
    input  logic       iIrqAck,
    output logic       oQuarterFrame,
    output logic       oHalfFrame,
    output logic       oIrq
);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    frame_mode_e      mode_q, mode_d;
    logic             quarter_q, quarter_d;
    logic             half_q, half_d;
    logic             dec_quarter, dec_half, dec_irq_set, dec_wrap;

    // Decode the value the counter is about to take, so pulses register on the same edge.
    assign cnt_inc = cnt_q + CNT_W'(1);

    frame_step_decode #(.CNT_W(CNT_W)) u_decode (
        .cnt_i     (cnt_inc),
        .mode_i    (mode_q),
        .quarter_o (dec_quarter),
        .half_o    (dec_half),
        .irq_set_o (dec_irq_set),
        .wrap_o    (dec_wrap)
    );

    always_comb begin
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        quarter_d = 1'b0;
        half_d    = 1'b0;
        if (iWrite) begin
            cnt_d     = '0;
            mode_d    = frame_mode_e'(iData[7]);
            quarter_d = iData[7];
            half_d    = iData[7];
        end else if (iCpuTick) begin
            if (dec_wrap) begin
                cnt_d = '0;
            end else begin
                cnt_d     = cnt_inc;
                quarter_d = dec_quarter;
                half_d    = dec_half;
            end
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            cnt_q     <= '0;
            mode_q    <= MODE_4STEP;
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            quarter_q <= quarter_d;
            half_q    <= half_d;
        end
    end

    assign oQuarterFrame = quarter_q;
    assign oHalfFrame    = half_q;

`ifdef FRAME_SEQ_IRQ_EN
    logic inhibit_q, inhibit_d;
    logic irq_q, irq_d;
    logic unused_data;

    assign unused_data = ^iData[5:0];

    always_comb begin
        inhibit_d = inhibit_q;
        irq_d     = irq_q;
        if (iWrite) begin
            inhibit_d = iData[6];
        end
        // Setting takes priority over a coincident acknowledge.
        if (!iWrite && iCpuTick && dec_irq_set && !inhibit_q) begin
            irq_d = 1'b1;
        end else if (iIrqAck || (iWrite && iData[6])) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
        end
    end

    assign oIrq = irq_q;
`else
    logic unused_irq;

    assign unused_irq = ^{iIrqAck, iData[6:0], dec_irq_set};
    assign oIrq       = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: short table of write/tick vectors plus
// long tick runs checked through an event scoreboard fed by a behavioural model.
module tb_frame_sequencer;

    logic       iClk = 1'b0;
    logic       iReset_n;
    logic       iCpuTick;
    logic       iWrite;
    logic [7:0] iData;
    logic       iIrqAck;
    logic       oQuarterFrame;
    logic       oHalfFrame;
    logic       oIrq;

    always #5 iClk = ~iClk;

    frame_sequencer #(.CNT_W(16)) dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iCpuTick      (iCpuTick),
        .iWrite        (iWrite),
        .iData         (iData),
        .iIrqAck       (iIrqAck),
        .oQuarterFrame (oQuarterFrame),
        .oHalfFrame    (oHalfFrame),
        .oIrq          (oIrq)
    );

`ifdef FRAME_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    // exp / qhi packing: {quarter, half, irq}
    typedef struct {
        logic       tick;
        logic       wr;
        logic [7:0] data;
        logic       ack;
        logic [2:0] exp;
    } vec_t;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  qhi;
    } ev_t;

    vec_t        vecs[9];
    ev_t         sb[$];
    int unsigned n_vec;
    int unsigned n_bad;
    int unsigned cyc;
    int unsigned m_cnt;
    bit          m_mode;
    bit          m_inh;
    bit          m_irq;
    logic        prev_irq;

    function automatic logic [2:0] dut_out();
        return {oQuarterFrame, oHalfFrame, oIrq};
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: q/h/irq got %b, expected %b", name, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_mode   = 1'b0;
        m_inh    = 1'b0;
        m_irq    = 1'b0;
        prev_irq = 1'b0;
        sb.delete();
    endtask

    task automatic step(input logic tick, input logic wr, input logic [7:0] data, input logic ack);
        logic [2:0]  exp_v;
        bit          was_irq;
        bit          set_irq;
        int unsigned last;
        ev_t         ev;
        @(negedge iClk);
        iCpuTick = tick;
        iWrite   = wr;
        iData    = data;
        iIrqAck  = ack;
        was_irq  = m_irq;
        exp_v    = 3'b000;
        set_irq  = 1'b0;
        if (wr) begin
            m_cnt    = 0;
            m_mode   = data[7];
            exp_v[2] = data[7];
            exp_v[1] = data[7];
            if (IRQ_EN) begin
                m_inh = data[6];
                if (data[6] || ack) m_irq = 1'b0;
            end
        end else begin
            if (tick) begin
                m_cnt++;
                if (m_cnt == (m_mode ? 37282 : 29830)) begin
                    m_cnt = 0;
                end else begin
                    last     = m_mode ? 37281 : 29829;
                    exp_v[2] = (m_cnt == 7457) || (m_cnt == 14913) || (m_cnt == 22371) || (m_cnt == last);
                    exp_v[1] = (m_cnt == 14913) || (m_cnt == last);
                    set_irq  = IRQ_EN && !m_mode && !m_inh && (m_cnt == 29829);
                end
            end
            if (set_irq) m_irq = 1'b1;
            else if (IRQ_EN && ack) m_irq = 1'b0;
        end
        exp_v[0] = m_irq;
        cyc++;
        if (exp_v[2] || exp_v[1] || (m_irq != was_irq)) sb.push_back('{cyc, exp_v});

        @(posedge iClk);
        #1;
        if (oQuarterFrame || oHalfFrame || (oIrq !== prev_irq)) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: cycle %0d q/h/irq got %b, expected no event", cyc, dut_out());
            end else begin
                ev = sb.pop_front();
                if (ev.cyc != cyc || ev.qhi !== dut_out()) begin
                    n_bad++;
                    $display("FAIL sb_event: got cycle %0d q/h/irq %b, expected cycle %0d q/h/irq %b",
                             cyc, dut_out(), ev.cyc, ev.qhi);
                end
            end
        end
        prev_irq = oIrq;
        iCpuTick = 1'b0;
        iWrite   = 1'b0;
        iData    = 8'h00;
        iIrqAck  = 1'b0;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain(input string name);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s: got %0d pending expected events (first due cycle %0d), expected 0",
                     name, sb.size(), sb[0].cyc);
            sb.delete();
        end
    endtask

    task automatic apply_reset();
        iCpuTick = 1'b0;
        iWrite   = 1'b0;
        iData    = 8'h00;
        iIrqAck  = 1'b0;
        iReset_n = 1'b0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iReset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'b000};
        vecs[1] = '{1'b0, 1'b1, 8'h80, 1'b0, 3'b110};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'b000};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'b000};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'b000};
        vecs[5] = '{1'b1, 1'b1, 8'h80, 1'b0, 3'b110};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 3'b000};
        vecs[7] = '{1'b0, 1'b1, 8'hC0, 1'b0, 3'b110};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'b000};
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;

        iCpuTick = 1'b0;
        iWrite   = 1'b0;
        iData    = 8'h00;
        iIrqAck  = 1'b0;
        iReset_n = 1'b0;
        #12;
        check("reset_state", dut_out(), 3'b000);
        apply_reset();

        for (int i = 0; i < 9; i++) begin
            @(negedge iClk);
            iCpuTick = vecs[i].tick;
            iWrite   = vecs[i].wr;
            iData    = vecs[i].data;
            iIrqAck  = vecs[i].ack;
            @(posedge iClk);
            #1;
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Full 4-step period from reset; ack lands on the cycle the IRQ sets.
        apply_reset();
        ticks(29828);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        drain("four_step_period");
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("irq_hold_wrap", {2'b00, oIrq}, {2'b00, IRQ_EN});
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("irq_ack_clear", dut_out(), 3'b000);

        // Write collides with the tick that would reach S1.
        ticks(7456);
        step(1'b1, 1'b1, 8'h00, 1'b0);
        drain("write_beats_tick");

        // 5-step period, including immediate pulses from the write and the silent S4.
        step(1'b0, 1'b1, 8'h80, 1'b0);
        ticks(37282);
        drain("five_step_period");

        // Asynchronous reset while the write-induced pulses are high in 5-step mode.
        step(1'b0, 1'b1, 8'h80, 1'b0);
        #2;
        iReset_n = 1'b0;
        #1;
        check("async_reset", dut_out(), 3'b000);
        @(posedge iClk);
        @(negedge iClk);
        iReset_n = 1'b1;
        model_reset();
        ticks(7457);
        drain("restart_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
